// File: rtl/ram_dma_pkg.sv
// Shared definitions for the scratch-RAM DMA initiator: op encodings,
// FSM state encodings and the address/data widths of the 32x8 scratch RAM.
package ram_dma_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_FIL  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/ram_dma.sv
// ram_dma: block COPY / FILL engine owning the scratch-RAM port while busy.
// The RAM reads asynchronously and writes on the clock edge, so a COPY byte
// takes one RD cycle (address out, data latched at the edge) and one WR cycle.
// RAM-port outputs are registered and loaded with the values for the state
// being entered, so they are stable for the whole cycle of that state.
// Optional feature macro: RAM_DMA_CHECKSUM_EN (running byte sum on chk);
// when undefined chk is tied to zero and no accumulator exists.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] chk,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  logic [2:0]    state;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_nx;
  logic [AW-1:0] len_m1;
  logic          last;

  // Byte index arithmetic; everything wraps mod 2**AW by width alone.
  assign idx_nx = idx + AW'(1);
  assign len_m1 = len_q - AW'(1);
  assign last   = (idx == len_m1);

  // Status decoded from registered state only.
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Command FSM; ram_din doubles as the COPY hold register (loaded in RD).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_q <= src;
            dst_q <= dst;
            len_q <= len;
            idx   <= '0;
            if (len == '0) begin
              state <= ST_DONE;
            end else if (op == OP_FILL) begin
              state    <= ST_FIL;
              ram_addr <= dst;
              ram_din  <= fill_val;
              ram_we   <= 1'b1;
            end else begin
              state    <= ST_RD;
              ram_addr <= src;
              ram_we   <= 1'b0;
            end
          end
        end
        ST_RD: begin
          state    <= ST_WR;
          ram_din  <= ram_dout;
          ram_addr <= dst_q + idx;
          ram_we   <= 1'b1;
        end
        ST_WR: begin
          if (last) begin
            state  <= ST_DONE;
            ram_we <= 1'b0;
          end else begin
            idx      <= idx_nx;
            state    <= ST_RD;
            ram_addr <= src_q + idx_nx;
            ram_we   <= 1'b0;
          end
        end
        ST_FIL: begin
          if (last) begin
            state  <= ST_DONE;
            ram_we <= 1'b0;
          end else begin
            idx      <= idx_nx;
            ram_addr <= dst_q + idx_nx;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAM_DMA_CHECKSUM_EN
  // Running sum of every byte that lands in the RAM; restarts per command.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk <= '0;
    end else if (state == ST_IDLE && start) begin
      chk <= '0;
    end else if (ram_we) begin
      chk <= chk + ram_din;
    end
  end
`else
  // No accumulator in this build.
  assign chk = '0;
`endif

endmodule
